// File: rtl/bsg_link_exerciser_pkg.sv
// ============================================================================
// Module      : bsg_link_exerciser_pkg
// Description : Shared mode encoding, LFSR step and default taps for the
//               link socket exerciser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bsg_link_exerciser_pkg;

    typedef enum logic [1:0] {
        e_drain    = 2'b00,
        e_loopback = 2'b01,
        e_lfsr     = 2'b10
    } mode_e;

    localparam logic [8:0] c_default_lfsr_taps = 9'h110;

    // Galois step on a 32-bit container; callers truncate to their width.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] taps);
        return (s >> 1) ^ (s[0] ? taps : 32'd0);
    endfunction

    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return e_loopback;
            2'b10:   return e_lfsr;
            default: return e_drain;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_link_exerciser_channel.sv
// ============================================================================
// Module      : bsg_link_exerciser_channel
// Description : One link channel: rx FIFO, tx credit counter, LFSR
//               generator/checker, token return and error tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_link_exerciser_channel
    import bsg_link_exerciser_pkg::*;
#(
    parameter int                 width_p         = 9,
    parameter int                 fifo_els_p      = 8,
    parameter int                 credits_p       = 8,
    parameter logic [width_p-1:0] lfsr_taps_p     = width_p'(c_default_lfsr_taps),
    parameter int                 err_cnt_width_p = 16,
    parameter logic [width_p-1:0] seed_p          = width_p'(1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       en_i,
    input  logic                       clear_i,
    input  mode_e                      mode_i,
    input  logic                       rx_v_i,
    input  logic [width_p-1:0]         rx_data_i,
    output logic                       rx_tkn_o,
    output logic                       tx_v_o,
    output logic [width_p-1:0]         tx_data_o,
    input  logic                       tx_tkn_i,
    output logic                       err_o,
    output logic [err_cnt_width_p-1:0] err_cnt_o,
    output logic                       ovf_o,
    output logic                       credit_err_o
);

    localparam int c_ptr_w  = $clog2(fifo_els_p);
    localparam int c_cred_w = $clog2(credits_p + 1);
    localparam logic [c_cred_w-1:0] c_cred_max = c_cred_w'(credits_p);

    logic [width_p-1:0]         r_mem [fifo_els_p];
    logic [c_ptr_w:0]           r_wptr, r_rptr;
    logic [c_cred_w-1:0]        r_credit;
    logic [width_p-1:0]         r_gen, r_chk;
    logic                       r_tx_v, r_tkn, r_err, r_ovf, r_credit_err;
    logic [width_p-1:0]         r_tx_data;
    logic [err_cnt_width_p-1:0] r_err_cnt;

    logic               w_empty, w_full, w_enq, w_deq, w_issue, w_mismatch, w_cred_over;
    logic [width_p-1:0] w_head, w_issue_data, w_gen_next, w_chk_next;
    mode_e              w_run_mode;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_ptr_w] != r_rptr[c_ptr_w]) &&
                     (r_wptr[c_ptr_w-1:0] == r_rptr[c_ptr_w-1:0]);
    assign w_enq   = rx_v_i & ~w_full;
    assign w_head  = r_mem[r_rptr[c_ptr_w-1:0]];

    // Disabled channels behave as drain regardless of the latched mode.
    assign w_run_mode = en_i ? mode_i : e_drain;

    assign w_gen_next = width_p'(lfsr_step(32'(r_gen), 32'(lfsr_taps_p)));
    assign w_chk_next = width_p'(lfsr_step(32'(r_chk), 32'(lfsr_taps_p)));

    always_comb begin
        w_deq        = 1'b0;
        w_issue      = 1'b0;
        w_issue_data = w_head;
        case (w_run_mode)
            e_loopback: begin
                w_deq   = ~w_empty && (r_credit != '0);
                w_issue = w_deq;
            end
            e_lfsr: begin
                w_deq        = ~w_empty;
                w_issue      = (r_credit != '0);
                w_issue_data = r_gen;
            end
            default: w_deq = ~w_empty;
        endcase
    end

    assign w_mismatch  = (w_run_mode == e_lfsr) && w_deq && (w_head != r_chk);
    assign w_cred_over = tx_tkn_i && !w_issue && (r_credit == c_cred_max);

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr[c_ptr_w-1:0]] <= rx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_credit     <= c_cred_max;
            r_gen        <= seed_p;
            r_chk        <= seed_p;
            r_tx_v       <= 1'b0;
            r_tx_data    <= '0;
            r_tkn        <= 1'b0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
            r_ovf        <= 1'b0;
            r_credit_err <= 1'b0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;

            case ({w_issue, tx_tkn_i})
                2'b10:   r_credit <= r_credit - c_cred_w'(1);
                2'b01:   if (r_credit != c_cred_max) r_credit <= r_credit + c_cred_w'(1);
                default: r_credit <= r_credit;
            endcase

            if (!en_i) begin
                r_gen <= seed_p;
                r_chk <= seed_p;
            end else if (w_run_mode == e_lfsr) begin
                if (w_issue) r_gen <= w_gen_next;
                if (w_deq)   r_chk <= w_chk_next;
            end

            r_tx_v <= w_issue;
            if (w_issue) r_tx_data <= w_issue_data;
            r_tkn  <= w_deq;

            // Clearing on the enable edge wins over any event in that cycle.
            if (clear_i) begin
                r_err        <= 1'b0;
                r_err_cnt    <= '0;
                r_ovf        <= 1'b0;
                r_credit_err <= 1'b0;
            end else begin
                if (w_mismatch) begin
                    r_err <= 1'b1;
                    if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (rx_v_i && w_full) r_ovf <= 1'b1;
                if (w_cred_over)      r_credit_err <= 1'b1;
            end
        end
    end

    assign rx_tkn_o     = r_tkn;
    assign tx_v_o       = r_tx_v;
    assign tx_data_o    = r_tx_data;
    assign err_o        = r_err;
    assign err_cnt_o    = r_err_cnt;
    assign ovf_o        = r_ovf;
    assign credit_err_o = r_credit_err;

endmodule

`default_nettype wire

// File: rtl/bsg_link_socket_exerciser.sv
// ============================================================================
// Module      : bsg_link_socket_exerciser
// Description : Multi-channel link exerciser: shared enable/mode latch plus
//               one independent channel engine per link pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_link_socket_exerciser
    import bsg_link_exerciser_pkg::*;
#(
    parameter int                 channels_p      = 20,
    parameter int                 width_p         = 9,
    parameter int                 fifo_els_p      = 8,
    parameter int                 credits_p       = 8,
    parameter logic [width_p-1:0] lfsr_taps_p     = width_p'(c_default_lfsr_taps),
    parameter int                 err_cnt_width_p = 16
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  en_i,
    input  logic [1:0]                            mode_i,
    input  logic [channels_p-1:0]                 rx_v_i,
    input  logic [channels_p*width_p-1:0]         rx_data_i,
    output logic [channels_p-1:0]                 rx_tkn_o,
    output logic [channels_p-1:0]                 tx_v_o,
    output logic [channels_p*width_p-1:0]         tx_data_o,
    input  logic [channels_p-1:0]                 tx_tkn_i,
    output logic [channels_p-1:0]                 err_o,
    output logic [channels_p*err_cnt_width_p-1:0] err_cnt_o,
    output logic [channels_p-1:0]                 ovf_o,
    output logic [channels_p-1:0]                 credit_err_o
);

    logic  r_en_d;
    mode_e r_mode;
    logic  w_en_rise;
    mode_e w_mode;

    assign w_en_rise = en_i & ~r_en_d;
    // The edge cycle already runs in the newly requested mode.
    assign w_mode    = w_en_rise ? decode_mode(mode_i) : r_mode;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_en_d <= 1'b0;
            r_mode <= e_drain;
        end else begin
            r_en_d <= en_i;
            if (w_en_rise) r_mode <= decode_mode(mode_i);
        end
    end

    for (genvar i = 0; i < channels_p; i++) begin : g_channel
        bsg_link_exerciser_channel #(
            .width_p         (width_p),
            .fifo_els_p      (fifo_els_p),
            .credits_p       (credits_p),
            .lfsr_taps_p     (lfsr_taps_p),
            .err_cnt_width_p (err_cnt_width_p),
            .seed_p          (width_p'(i + 1))
        ) u_channel (
            .clk_i        (clk_i),
            .reset_n_i    (reset_n_i),
            .en_i         (en_i),
            .clear_i      (w_en_rise),
            .mode_i       (w_mode),
            .rx_v_i       (rx_v_i[i]),
            .rx_data_i    (rx_data_i[i*width_p +: width_p]),
            .rx_tkn_o     (rx_tkn_o[i]),
            .tx_v_o       (tx_v_o[i]),
            .tx_data_o    (tx_data_o[i*width_p +: width_p]),
            .tx_tkn_i     (tx_tkn_i[i]),
            .err_o        (err_o[i]),
            .err_cnt_o    (err_cnt_o[i*err_cnt_width_p +: err_cnt_width_p]),
            .ovf_o        (ovf_o[i]),
            .credit_err_o (credit_err_o[i])
        );
    end

endmodule

`default_nettype wire

// File: doc/bsg_link_socket_exerciser.md
Name: bsg_link_socket_exerciser

Overview:
- Parametrised, single-clock, multi-channel link exerciser for socket-level ASIC testing.
- Sits on the board/FPGA side of the socket, facing each chip link pair. It terminates the chip's link-out channels with token flow control.
- Per channel, it either loops traffic back into the chip's link-in channels or generates and checks LFSR traffic.
- Compared with a plain pin-level socket, it adds buffering, credit tracking, error counting and a run mode.

Parameters:
- channels_p, 20, number of full-duplex link channels.
- width_p, 9, data bits per link word.
- fifo_els_p, 8, rx FIFO depth per channel; power of 2, >= credits_p.
- credits_p, 8, initial tx credits per channel.
- lfsr_taps_p, 9'h110, Galois LFSR tap mask (x^9+x^5+1); width width_p.
- err_cnt_width_p, 16, per-channel error counter width.

Ports:
- clk_i  input  1  core clock; all logic.
- reset_n_i  input  1  asynchronous, active-low reset.
- en_i  input  1  run enable.
- mode_i  input  2  00 drain, 01 loopback, 10 lfsr, 11 reserved (treated as drain).
- rx_v_i  input  channels_p  word valid from chip link-out.
- rx_data_i  input  channels_p x width_p  data from chip link-out.
- rx_tkn_o  output  channels_p  token pulse back to chip link-out.
- tx_v_o  output  channels_p  word valid to chip link-in.
- tx_data_o  output  channels_p x width_p  data to chip link-in.
- tx_tkn_i  input  channels_p  token pulse from chip link-in.
- err_o  output  channels_p  sticky data-mismatch flag.
- err_cnt_o  output  channels_p x err_cnt_width_p  saturating mismatch count.
- ovf_o  output  channels_p  sticky rx FIFO overflow.
- credit_err_o  output  channels_p  sticky token-above-limit flag.

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; FIFOs empty; credit counters = credits_p.
  - LFSR gen/check states = channel index + 1 (nonzero).
  - mode register = 00.
- mode_i is latched on the en_i 0->1 edge.
- While en_i=0:
  - no tx issue.
  - FIFO drains as in mode 00.
  - LFSR states reload seeds.
- On the en_i rising edge, err_o, err_cnt_o, ovf_o and credit_err_o clear.
- Rx enqueue:
  - rx_v_i=1 enqueues rx_data_i the same cycle.
  - If the FIFO is full, the word is dropped and ovf_o sets; no other effect.
- Dequeue condition per mode:
  - Mode 00: head dequeued every cycle the FIFO is non-empty; data discarded.
  - Mode 01: head dequeued when non-empty and credit>0. Dequeue drives registered tx_v_o=1 and tx_data_o=head the next cycle.
  - Mode 10: head dequeued every non-empty cycle and compared with the checker LFSR state.
- Mode 10 checker:
  - On mismatch, err_o sets and err_cnt_o increments, saturating at all-ones.
  - The checker LFSR advances on every dequeue, match or not.
- Mode 10 generator:
  - When en_i=1 and credit>0, tx_v_o=1 with tx_data_o = generator state (registered).
  - The generator then advances.
- LFSR step: next = (s >> 1) ^ (s[0] ? lfsr_taps_p : 0).
- Token return: every dequeue (any mode) produces a registered 1-cycle rx_tkn_o pulse the next cycle.
- Latency: rx_v_i in cycle N (empty FIFO, credit available, mode 01) gives tx_v_o and rx_tkn_o in cycle N+2.
- Credit counter (width clog2(credits_p+1)):
  - Decrements on tx issue; increments on tx_tkn_i.
  - Simultaneous issue and token: unchanged.
  - Token while counter == credits_p with no issue: counter holds, credit_err_o sets.
  - A tx issue never happens at credit 0.
- tx_v_o is 0 whenever no issue occurred in the previous cycle; tx_data_o holds its last value.
- Channels are fully independent; a single channel's error never affects others.
- Reset mid-operation: all state returns to reset values immediately; in-flight words are lost.

Decomposition:
- Shared package bsg_link_exerciser_pkg holds:
  - mode enum (e_drain, e_loopback, e_lfsr);
  - the LFSR step function;
  - default tap constant.
- One sub-module, bsg_link_exerciser_channel: FIFO, credit counter, generator/checker and token logic for one channel.
- The top generates channels_p instances plus shared mode/enable-edge logic.

Test Plan:
- Reset: assert reset_n_i=0 mid-traffic -> all outputs 0 immediately; after release, credits=8 and err_cnt_o=0.
- Loopback: mode 01, rx word 9'h1A5 in cycle N on ch3 -> tx_v_o[3]=1, tx_data_o[3]=9'h1A5 and rx_tkn_o[3]=1 at N+2; other channels idle.
- Credits: credits_p=4, no tx_tkn_i, 6 rx words -> exactly 4 tx words. One tx_tkn_i pulse -> 5th word 2 cycles later. Token and issue in the same cycle -> credit unchanged.
- LFSR: mode 10, tx externally wired to rx on all channels -> err_cnt_o=0 after 1000 words. Flip bit 0 of one word on ch7 -> err_cnt_o[7]=1, err_o[7]=1, others 0.
- Overflow: fifo_els_p=4, mode 01, credit exhausted, 5 rx words -> ovf_o=1, 4 words later loop out after tokens.
- Credit error: extra tx_tkn_i with credit=credits_p -> credit_err_o=1, counter stays 8.
